// File: rtl/shift_sequencer_pkg.sv
// Shared encodings for the shift sequencer: operation codes and FSM states.
package shift_sequencer_pkg;

    typedef enum logic [1:0] {
        OP_SHL = 2'b00,
        OP_SHR = 2'b01,
        OP_ROL = 2'b10,
        OP_ROR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/shift_sequencer_shift_step.sv
// One single-bit shift/rotate step; bit_out is the bit leaving the word.
import shift_sequencer_pkg::*;

module shift_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] work,
    input  op_e              op,
    output logic [WIDTH-1:0] next_work,
    output logic             bit_out
);

    // Step selection by operation
    always_comb begin
        next_work = work;
        bit_out   = 1'b0;
        case (op)
            OP_SHL: begin
                next_work = {work[WIDTH-2:0], 1'b0};
                bit_out   = work[WIDTH-1];
            end
            OP_SHR: begin
                next_work = {1'b0, work[WIDTH-1:1]};
                bit_out   = work[0];
            end
            OP_ROL: begin
                next_work = {work[WIDTH-2:0], work[WIDTH-1]};
                bit_out   = work[WIDTH-1];
            end
            OP_ROR: begin
                next_work = {work[0], work[WIDTH-1:1]};
                bit_out   = work[0];
            end
            default: begin
                next_work = work;
                bit_out   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift/rotate sequencer: one bit per cycle, result held until consumed.
import shift_sequencer_pkg::*;

module shift_sequencer #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [CNT_WIDTH-1:0] cnt,
    input  logic [1:0]           op,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [WIDTH-1:0]     out,
    output logic                 co,
    output logic                 busy
);

    state_e               state_r, state_s;
    logic [WIDTH-1:0]     work_r;
    logic [CNT_WIDTH-1:0] rem_r;
    op_e                  op_r;
    logic                 carry_r;
    logic                 res_valid_r;
    logic [WIDTH-1:0]     out_r;
    logic                 co_r;
    logic [WIDTH-1:0]     next_work_s;
    logic                 bit_out_s;
    logic                 accept_s, step_s, finish_s, release_s;
    logic                 final_co_s;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .work      (work_r),
        .op        (op_r),
        .next_work (next_work_s),
        .bit_out   (bit_out_s)
    );

    // Next-state and datapath control decode
    always_comb begin
        state_s   = state_r;
        accept_s  = 1'b0;
        step_s    = 1'b0;
        finish_s  = 1'b0;
        release_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    accept_s = 1'b1;
                    state_s  = ST_RUN;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (rem_r != {CNT_WIDTH{1'b0}}) begin
                    step_s   = 1'b1;
                    state_s  = ST_RUN;
                end else begin
                    finish_s = 1'b1;
                    state_s  = ST_DONE;
                end
            end
            ST_DONE: begin
                // Leave only once the result has actually been presented
                if (res_valid_r && res_ready) begin
                    release_s = 1'b1;
                    state_s   = ST_IDLE;
                end else begin
                    state_s   = ST_DONE;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Rotates report the bit that wrapped last, which also covers a zero count
    always_comb begin
        final_co_s = carry_r;
        case (op_r)
            OP_ROL:  final_co_s = work_r[0];
            OP_ROR:  final_co_s = work_r[WIDTH-1];
            default: final_co_s = carry_r;
        endcase
    end

    // State, working registers and registered result
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            work_r      <= {WIDTH{1'b0}};
            rem_r       <= {CNT_WIDTH{1'b0}};
            op_r        <= OP_SHL;
            carry_r     <= 1'b0;
            res_valid_r <= 1'b0;
            out_r       <= {WIDTH{1'b0}};
            co_r        <= 1'b0;
        end else begin
            state_r     <= state_s;
            res_valid_r <= (state_r == ST_DONE) && !release_s;
            if (accept_s) begin
                work_r  <= a;
                rem_r   <= cnt;
                op_r    <= op_e'(op);
                carry_r <= 1'b0;
            end else if (step_s) begin
                work_r  <= next_work_s;
                rem_r   <= rem_r - CNT_WIDTH'(1);
                carry_r <= bit_out_s;
            end else if (finish_s) begin
                out_r   <= work_r;
                co_r    <= final_co_s;
            end else begin
                work_r  <= work_r;
            end
        end
    end

    assign req_ready = (state_r == ST_IDLE);
    assign busy      = (state_r != ST_IDLE);
    assign res_valid = res_valid_r;
    assign out       = out_r;
    assign co        = co_r;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with an arithmetic reference model.
module tb_shift_sequencer;

    logic       clk = 1'b0;
    logic       rst, req_valid, req_ready, res_valid, res_ready, co, busy;
    logic [7:0] a, cnt, out;
    logic [1:0] op;

    int   n_tests = 0;
    int   n_fail  = 0;
    logic [7:0] mdl_out = 8'h00;
    logic       mdl_co  = 1'b0;
    logic       valid_expected = 1'b0;

    shift_sequencer #(.WIDTH(8), .CNT_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .a(a), .cnt(cnt), .op(op), .res_valid(res_valid), .res_ready(res_ready),
        .out(out), .co(co), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: shift results from plain arithmetic, rotates from mod-WIDTH rotation
    task automatic model(input int av, input int c, input int o, output logic [7:0] ro, output logic rc);
        int v, r;
        v = av & 255;
        case (o)
            0: begin
                v  = (c >= 8) ? 0 : ((av << c) & 255);
                rc = (c == 0 || c > 8) ? 1'b0 : 1'((av >> (8 - c)) & 1);
            end
            1: begin
                v  = (c >= 8) ? 0 : (av >> c);
                rc = (c == 0 || c > 8) ? 1'b0 : 1'((av >> (c - 1)) & 1);
            end
            2: begin
                r  = c % 8;
                v  = ((av << r) | (av >> (8 - r))) & 255;
                rc = 1'(v & 1);
            end
            default: begin
                r  = c % 8;
                v  = ((av >> r) | (av << (8 - r))) & 255;
                rc = 1'((v >> 7) & 1);
            end
        endcase
        ro = 8'(v);
    endtask

    // Continuous result check against the model whenever a result is presented
    always @(negedge clk) begin
        if (!rst && res_valid) begin
            chk("res_valid_expected", 32'(valid_expected), 1);
            chk("out_vs_model", 32'(out), 32'(mdl_out));
            chk("co_vs_model", 32'(co), 32'(mdl_co));
        end
    end

    task automatic run_op(input logic [7:0] ai, input logic [7:0] ci, input logic [1:0] oi,
                          input logic [7:0] lit_out, input logic lit_co, input int hold);
        int lat;
        logic [7:0] held_out;
        logic       held_co;
        model(int'(ai), int'(ci), int'(oi), mdl_out, mdl_co);
        chk("model_pin_out", 32'(mdl_out), 32'(lit_out));
        chk("model_pin_co", 32'(mdl_co), 32'(lit_co));
        chk("idle_req_ready", 32'(req_ready), 1);
        valid_expected = 1'b1;
        a = ai; cnt = ci; op = oi; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("run_busy", 32'(busy), 1);
        chk("run_req_ready", 32'(req_ready), 0);
        lat = 0;
        while (!res_valid && lat < 400) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, int'(ci) + 2);
        chk("lit_out", 32'(out), 32'(lit_out));
        chk("lit_co", 32'(co), 32'(lit_co));
        held_out = out;
        held_co  = co;
        for (int i = 0; i < hold; i++) begin
            a = ~ai; cnt = 8'd1; op = 2'b00; req_valid = 1'b1;
            @(posedge clk); #1;
            chk("hold_valid", 32'(res_valid), 1);
            chk("hold_req_ready", 32'(req_ready), 0);
            chk("hold_out", 32'(out), 32'(held_out));
            chk("hold_co", 32'(co), 32'(held_co));
        end
        req_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        valid_expected = 1'b0;
        chk("release_valid", 32'(res_valid), 0);
        chk("release_busy", 32'(busy), 0);
        chk("idle_out_held", 32'(out), 32'(held_out));
        chk("idle_co_held", 32'(co), 32'(held_co));
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; res_ready = 1'b0;
        a = 8'h00; cnt = 8'h00; op = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_valid", 32'(res_valid), 0);
        chk("rst_out", 32'(out), 0);
        chk("rst_co", 32'(co), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(8'h81, 8'd1,   2'b00, 8'h02, 1'b1, 5);
        run_op(8'hB4, 8'd3,   2'b11, 8'h96, 1'b1, 0);
        run_op(8'hB4, 8'd11,  2'b10, 8'hA5, 1'b1, 0);
        run_op(8'hFF, 8'd0,   2'b01, 8'hFF, 1'b0, 0);
        run_op(8'h01, 8'd9,   2'b01, 8'h00, 1'b0, 0);
        run_op(8'h01, 8'd8,   2'b00, 8'h00, 1'b1, 0);
        run_op(8'hC3, 8'd0,   2'b10, 8'hC3, 1'b1, 0);
        run_op(8'hC3, 8'd0,   2'b11, 8'hC3, 1'b1, 0);
        run_op(8'h80, 8'd8,   2'b01, 8'h00, 1'b1, 0);
        run_op(8'h96, 8'd4,   2'b00, 8'h60, 1'b1, 0);
        run_op(8'h96, 8'd2,   2'b01, 8'h25, 1'b1, 2);
        run_op(8'h3C, 8'd16,  2'b11, 8'h3C, 1'b0, 0);
        run_op(8'h81, 8'd255, 2'b10, 8'hC0, 1'b0, 0);

        // Abort a long shift: reset wins over a simultaneous request
        valid_expected = 1'b0;
        a = 8'h81; cnt = 8'd200; op = 2'b00; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1; req_valid = 1'b1; a = 8'h0F; cnt = 8'd1;
        @(posedge clk); #1;
        rst = 1'b0; req_valid = 1'b0;
        chk("abort_req_ready", 32'(req_ready), 1);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_out", 32'(out), 0);
        chk("abort_co", 32'(co), 0);
        chk("abort_valid", 32'(res_valid), 0);
        repeat (210) @(posedge clk);
        #1;
        chk("abort_still_idle", 32'(busy), 0);
        run_op(8'h96, 8'd4, 2'b00, 8'h60, 1'b1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width.
REQ-002 Parameter CNT_WIDTH, default 8: width of the shift-count field; counts up to 2^CNT_WIDTH-1.
REQ-003 clk  input  1: single clock; all state updates on rising edge.
REQ-004 rst  input  1: reset, synchronous, active-high.
REQ-005 req_valid  input  1: request present on a, cnt, op.
REQ-006 req_ready  output  1: sequencer can accept a request this cycle.
REQ-007 a  input  WIDTH: operand.
REQ-008 cnt  input  CNT_WIDTH: number of single-bit steps.
REQ-009 op  input  2: 00 SHL, 01 SHR (logical), 10 ROL, 11 ROR.
REQ-010 res_valid  output  1: result present on out, co.
REQ-011 res_ready  input  1: consumer accepts the result.
REQ-012 out  output  WIDTH: shifted/rotated result.
REQ-013 co  output  1: carry flag.
REQ-014 busy  output  1: high in any state other than IDLE.

Function
REQ-015 The block SHALL be an FSM with states IDLE, RUN, DONE.
REQ-016 IDLE: req_ready=1; on req_valid&req_ready, a/cnt/op SHALL be latched into work register, remaining-count register and op register, co cleared, transition to RUN.
REQ-017 RUN: each cycle with remaining>0, the work register SHALL advance exactly one bit per op, remaining decrements by 1.
REQ-018 RUN with remaining==0 (including cnt==0 at accept): transition to DONE without modifying the work register.
REQ-019 Latency: res_valid SHALL rise exactly cnt+2 cycles after the accept edge (cnt step cycles, one terminal RUN cycle, one registration cycle).
REQ-020 DONE: res_valid=1, out and co stable; on res_ready=1 transition to IDLE; with res_ready=0 hold DONE indefinitely, outputs unchanged.
REQ-021 req_ready SHALL be 0 in RUN and DONE; requests then are ignored, not queued.
REQ-022 SHL step: co <= work[WIDTH-1], work <= {work[WIDTH-2:0],0}.
REQ-023 SHR step: co <= work[0], work <= {0,work[WIDTH-1:1]}.
REQ-024 ROL step: work <= {work[WIDTH-2:0],work[WIDTH-1]}; final co SHALL equal out[0].
REQ-025 ROR step: work <= {work[0],work[WIDTH-1:1]}; final co SHALL equal out[WIDTH-1].
REQ-026 cnt==0: out=a; co=0 for SHL/SHR; co=out[0] for ROL, out[WIDTH-1] for ROR.
REQ-027 cnt>=WIDTH for SHL/SHR: out=0; co = last bit shifted out (0 when cnt>WIDTH, a[0]/a[WIDTH-1] for SHL/SHR when cnt==WIDTH).
REQ-028 Rotates SHALL run all cnt steps literally (no modulo shortcut); result equals rotation by cnt mod WIDTH.
REQ-029 out and co SHALL only change in RUN; in IDLE they hold the last result.

Reset
REQ-030 rst=1 at a clock edge SHALL force IDLE, out=0, co=0, res_valid=0, busy=0, req_ready=1 on the following cycle, from any state.
REQ-031 rst during RUN or DONE SHALL discard the in-flight operation; no res_valid pulse follows.
REQ-032 rst has priority over simultaneous req_valid.

Structure
REQ-033 A shared package SHALL hold the op encoding enum (SHL, SHR, ROL, ROR) and the state enum.
REQ-034 The single-bit step logic SHALL be a combinational sub-module shift_step (inputs work, op; outputs next_work, bit_out); FSM and counter stay in shift_sequencer.

Verification
REQ-035 a=8'h81, cnt=1, op=SHL -> out=8'h02, co=1, res_valid 3 cycles after accept.
REQ-036 a=8'hB4, cnt=3, op=ROR -> out=8'h96, co=1; repeat op=ROL cnt=11 -> out=8'hA5, co=1.
REQ-037 a=8'hFF, cnt=0, op=SHR -> out=8'hFF, co=0, res_valid 2 cycles after accept.
REQ-038 a=8'h01, cnt=9, op=SHR -> out=8'h00, co=0; cnt=8, op=SHL, a=8'h01 -> out=0, co=1.
REQ-039 Hold res_ready=0 for 5 cycles in DONE while driving req_valid=1 -> outputs stable, req_ready=0, no new accept.
REQ-040 Assert rst 2 cycles into a cnt=200 SHL -> IDLE next cycle, out=0, co=0, no res_valid.
